my_irq: RTL and testbench



---
 rtl/my_irq_pkg.sv | 23 ++
 rtl/my_irq_axi_regs.sv | 112 +++++++++++
 rtl/my_irq.sv | 72 +++++++
 tb/tb_my_irq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_irq_pkg.sv
// Shared constants for the my_irq peripheral: register map, IRQ enable bit
// position, AXI response code and a byte-strobe expansion helper.
package my_irq_pkg;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_CLEAR  = 5'd2;
  localparam logic [4:0] REG_MASK   = 5'd3;

  localparam int unsigned IRQ_EN = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/my_irq_axi_regs.sv
// AXI4-Lite slave with a 32 x 32 register file; STATUS is set-on-write and
// cleared through the write-only CLEAR register.
module my_irq_axi_regs
  import my_irq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              irq_en_o,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] mask_o
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_accept, rd_accept;
  logic [4:0]        wr_idx, rd_idx;
  logic [DATA_W-1:0] wmask, wbits;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  assign wr_idx = awaddr[ADDR_W-1:2];
  assign rd_idx = araddr[ADDR_W-1:2];

  always_comb begin
    regs_d    = regs_q;
    wmask     = strb_to_mask(wstrb);
    wbits     = wdata & wmask;
    wr_accept = awvalid & wvalid & ~awready_q & ~bvalid_q;
    rd_accept = arvalid & ~arready_q & ~rvalid_q;

    if (wr_accept) begin
      case (wr_idx)
        REG_STATUS: regs_d[REG_STATUS] = regs_q[REG_STATUS] | wbits;
        REG_CLEAR:  regs_d[REG_STATUS] = regs_q[REG_STATUS] & ~wbits;
        default:    regs_d[wr_idx]     = (regs_q[wr_idx] & ~wmask) | wbits;
      endcase
    end

    awready_d = wr_accept;
    bvalid_d  = awready_q ? 1'b1 : (bready ? 1'b0 : bvalid_q);

    // Read data is sampled on the accept edge, so a same-cycle write is not seen.
    arready_d = rd_accept;
    rdata_d   = rdata_q;
    if (rd_accept) begin
      rdata_d = (rd_idx == REG_CLEAR) ? '0 : regs_q[rd_idx];
    end
    rvalid_d = arready_q ? 1'b1 : (rready ? 1'b0 : rvalid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = awready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = RESP_OKAY;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = RESP_OKAY;
  assign irq_en_o = regs_q[REG_CTRL][IRQ_EN];
  assign status_o = regs_q[REG_STATUS];
  assign mask_o   = regs_q[REG_MASK];

endmodule

// File: rtl/my_irq.sv
// my_irq top: AXI4-Lite register block plus a level interrupt driven from
// CTRL enable, pending STATUS bits and MASK.
module my_irq
  import my_irq_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 7,
  parameter int C_IRQ_ACTIVE_STATE   = 1
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [3:0]                        s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              irq
);

  logic                            irq_en;
  logic [C_S00_AXI_DATA_WIDTH-1:0] status;
  logic [C_S00_AXI_DATA_WIDTH-1:0] mask;
  logic                            irq_req;

  my_irq_axi_regs #(
    .DATA_W (C_S00_AXI_DATA_WIDTH),
    .ADDR_W (C_S00_AXI_ADDR_WIDTH)
  ) u_regs (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .awaddr   (s00_axi_awaddr),
    .awprot   (s00_axi_awprot),
    .awvalid  (s00_axi_awvalid),
    .awready  (s00_axi_awready),
    .wdata    (s00_axi_wdata),
    .wstrb    (s00_axi_wstrb),
    .wvalid   (s00_axi_wvalid),
    .wready   (s00_axi_wready),
    .bresp    (s00_axi_bresp),
    .bvalid   (s00_axi_bvalid),
    .bready   (s00_axi_bready),
    .araddr   (s00_axi_araddr),
    .arprot   (s00_axi_arprot),
    .arvalid  (s00_axi_arvalid),
    .arready  (s00_axi_arready),
    .rdata    (s00_axi_rdata),
    .rresp    (s00_axi_rresp),
    .rvalid   (s00_axi_rvalid),
    .rready   (s00_axi_rready),
    .irq_en_o (irq_en),
    .status_o (status),
    .mask_o   (mask)
  );

  assign irq_req = irq_en & (|(status & mask));
  assign irq     = (C_IRQ_ACTIVE_STATE != 0) ? irq_req : ~irq_req;

endmodule

// File: tb/tb_my_irq.sv
// Scoreboard bench for my_irq: tasks queue expected B/R responses, a negedge
// monitor pops and compares them on each completed handshake.
module tb_my_irq;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [6:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        irq;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_b[$];
  logic        irq_at_accept;

  always #5 clk = ~clk;

  my_irq dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rstn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .irq             (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rstn && bvalid && bready) begin
      if (exp_b.size() == 0) check("unexpected_bresp", 32'd1, 32'd0);
      else check("bresp", {30'd0, bresp}, {30'd0, exp_b.pop_front()});
    end
    if (rstn && rvalid && rready) begin
      if (exp_rd.size() == 0) check("unexpected_rdata", 32'd1, 32'd0);
      else begin
        check("rdata", rdata, exp_rd.pop_front());
        check("rresp", {30'd0, rresp}, 32'd0);
      end
    end
  end

  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int cyc;
    bit ok;
    exp_b.push_back(2'b00);
    bready  = (hold == 0);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    cyc = 0;
    ok  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; cyc++;
      if (awready) begin ok = 1; break; end
    end
    if (!ok) check("awready_timeout", 32'd0, 32'd1);
    check("wready_with_awready", {31'd0, wready}, 32'd1);
    irq_at_accept = irq;
    @(posedge clk); #1; cyc++;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("b_latency", cyc, 32'd2);
    check("awready_one_cycle", {31'd0, awready}, 32'd0);
    check("bvalid_rise", {31'd0, bvalid}, 32'd1);
    if (hold > 0) begin
      // A competing write is offered during backpressure and must be refused.
      awvalid = 1'b1;
      wvalid  = 1'b1;
      wdata   = ~data;
      wstrb   = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
        check("bp_no_awready", {31'd0, awready}, 32'd0);
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b1;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bvalid) begin ok = 1; break; end
    end
    if (!ok) check("bvalid_drop_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [6:0] addr, input logic [31:0] exp, input int hold);
    bit ok;
    exp_rd.push_back(exp);
    rready  = (hold == 0);
    araddr  = addr;
    arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) begin ok = 1; break; end
    end
    if (!ok) check("arready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("arready_one_cycle", {31'd0, arready}, 32'd0);
    check("rvalid_rise", {31'd0, rvalid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_rvalid_held", {31'd0, rvalid}, 32'd1);
      check("bp_rdata_stable", rdata, exp);
    end
    rready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!rvalid) begin ok = 1; break; end
    end
    if (!ok) check("rvalid_drop_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, {31'd0, awready}, 32'd0);
    check({tag, "_wready"},  {31'd0, wready},  32'd0);
    check({tag, "_bvalid"},  {31'd0, bvalid},  32'd0);
    check({tag, "_arready"}, {31'd0, arready}, 32'd0);
    check({tag, "_rvalid"},  {31'd0, rvalid},  32'd0);
    check({tag, "_rdata"},   rdata,            32'd0);
    check({tag, "_irq"},     {31'd0, irq},     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    irq_at_accept = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) axi_read(7'(i * 4), 32'd0, 0);

    axi_write(7'h10, 32'hDEADBEEF, 4'hF, 0);
    axi_read(7'h10, 32'hDEADBEEF, 0);
    axi_read(7'h13, 32'hDEADBEEF, 0);

    axi_write(7'h14, 32'hFFFFFFFF, 4'h5, 0);
    axi_read(7'h14, 32'h00FF00FF, 0);
    axi_write(7'h14, 32'h12345678, 4'h0, 0);
    axi_read(7'h14, 32'h00FF00FF, 0);

    axi_write(7'h00, 32'h1, 4'hF, 0);
    axi_write(7'h0C, 32'h1, 4'hF, 0);
    check("irq_no_pending", {31'd0, irq}, 32'd0);
    axi_write(7'h04, 32'h1, 4'hF, 0);
    check("irq_at_status_set", {31'd0, irq_at_accept}, 32'd1);
    check("irq_pending", {31'd0, irq}, 32'd1);
    axi_write(7'h08, 32'h1, 4'hF, 0);
    check("irq_at_clear", {31'd0, irq_at_accept}, 32'd0);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    axi_read(7'h04, 32'h0, 0);
    axi_read(7'h08, 32'h0, 0);

    axi_write(7'h04, 32'h2, 4'hF, 0);
    check("irq_masked", {31'd0, irq}, 32'd0);
    axi_write(7'h00, 32'h0, 4'hF, 0);
    axi_write(7'h0C, 32'h3, 4'hF, 0);
    check("irq_global_off", {31'd0, irq}, 32'd0);
    axi_write(7'h00, 32'h1, 4'hF, 0);
    check("irq_global_on", {31'd0, irq}, 32'd1);
    axi_read(7'h00, 32'h1, 0);
    axi_read(7'h0C, 32'h3, 0);
    axi_read(7'h04, 32'h2, 0);
    axi_write(7'h08, 32'hFFFFFFFF, 4'h0, 0);
    check("irq_clear_no_strobe", {31'd0, irq}, 32'd1);
    axi_write(7'h08, 32'h2, 4'h1, 0);
    check("irq_clear_bit1", {31'd0, irq}, 32'd0);

    axi_write(7'h18, 32'hCAFEF00D, 4'hF, 5);
    axi_read(7'h18, 32'hCAFEF00D, 5);

    // Reset in the middle of an unacknowledged write.
    bready  = 1'b0;
    awaddr  = 7'h1C;
    wdata   = 32'hA5A5A5A5;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_bvalid_before", {31'd0, bvalid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(posedge clk); #1;
    rstn   = 1'b1;
    bready = 1'b1;
    @(posedge clk); #1;
    axi_read(7'h1C, 32'h0, 0);
    axi_read(7'h10, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("pending_b_expectations", exp_b.size(), 32'd0);
    check("pending_r_expectations", exp_rd.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
